// File: rtl/mat_stream_pkg.sv
// Shared types and helpers for the matrix result streamer and the multiplier-side packing.
package mat_stream_pkg;

  typedef enum logic {
    IDLE,
    STREAM
  } state_e;

  // Row-index width, never narrower than one bit so N=1 still has a counter.
  function automatic int calc_row_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int elem_offset(input int r, input int c, input int n, input int w);
    return (r * n + c) * w;
  endfunction

endpackage

// File: rtl/mat_row_select.sv
// Combinational N:1 beat selector from the flat matrix buffer.
// MAT_STREAM_TRANSPOSE_EN: beats carry columns instead of rows.
module mat_row_select
  import mat_stream_pkg::*;
#(
  parameter int W_OUT = 32,
  parameter int N     = 8,
  parameter int ROW_W = calc_row_w(N)
) (
  input  logic [N*N*W_OUT-1:0] mat_i,
  input  logic [ROW_W-1:0]     sel_i,
  output logic [N*W_OUT-1:0]   beat_o
);

  always_comb begin
    beat_o = '0;
    for (int c = 0; c < N; c++) begin
`ifdef MAT_STREAM_TRANSPOSE_EN
      beat_o[c*W_OUT +: W_OUT] = mat_i[elem_offset(c, int'(sel_i), N, W_OUT) +: W_OUT];
`else
      beat_o[c*W_OUT +: W_OUT] = mat_i[elem_offset(int'(sel_i), c, N, W_OUT) +: W_OUT];
`endif
    end
  end

endmodule

// File: rtl/mat_result_streamer.sv
// Captures one N x N result matrix on a strobe and drains it one row per valid/ready beat.
// MAT_STREAM_TRANSPOSE_EN (in mat_row_select) switches beats to column order.
module mat_result_streamer
  import mat_stream_pkg::*;
#(
  parameter int W_OUT = 32,
  parameter int N     = 8,
  parameter int ROW_W = calc_row_w(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cen,
  input  logic                 valid_in,
  input  logic [N*N*W_OUT-1:0] result_in,
  output logic                 in_ready,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [N*W_OUT-1:0]   m_data,
  output logic [ROW_W-1:0]     m_row,
  output logic                 m_last,
  output logic                 overflow
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N - 1);

  state_e                 state_q, state_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic [N*N*W_OUT-1:0]   buf_q, buf_d;
  logic                   overflow_q, overflow_d;

  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
    state_d    = state_q;
    row_d      = row_q;
    buf_d      = buf_q;
    overflow_d = overflow_q;

    m_valid  = (state_q == STREAM);
    m_last   = m_valid && (row_q == LAST_ROW);
    in_ready = (state_q == IDLE) || (m_last && m_ready);

    if (cen) begin
      if (m_valid && m_ready) begin
        if (m_last) begin
          state_d = IDLE;
          row_d   = '0;
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end
      // A capture on the last-row accept overrides the return to IDLE (chaining).
      if (valid_in) begin
        if (in_ready) begin
          buf_d   = result_in;
          row_d   = '0;
          state_d = STREAM;
        end else begin
          overflow_d = 1'b1;
        end
      end
    end
  end

  // NOTE: the matrix buffer is reset as well, so m_data reads zero before the first capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      row_q      <= '0;
      buf_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      buf_q      <= buf_d;
      overflow_q <= overflow_d;
    end
  end

  mat_row_select #(
    .W_OUT (W_OUT),
    .N     (N),
    .ROW_W (ROW_W)
  ) u_row_select (
    .mat_i  (buf_q),
    .sel_i  (row_q),
    .beat_o (m_data)
  );

  assign m_row    = row_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_mat_result_streamer.sv
// Directed self-checking bench for mat_result_streamer with N=2, W_OUT=32.
module tb_mat_result_streamer;

  localparam int W_OUT = 32;
  localparam int N     = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 cen;
  logic                 valid_in;
  logic [N*N*W_OUT-1:0] result_in;
  logic                 in_ready;
  logic                 m_valid;
  logic                 m_ready;
  logic [N*W_OUT-1:0]   m_data;
  logic [0:0]           m_row;
  logic                 m_last;
  logic                 overflow;

  int n_cmp = 0;
  int n_err = 0;

  // Matrix A: (0,0)=1 (0,1)=-2 (1,0)=3 (1,1)=4 ; Matrix B: 5, 6, 7, -8
  localparam logic [127:0] MAT_A = {32'sd4, 32'sd3, -32'sd2, 32'sd1};
  localparam logic [127:0] MAT_B = {-32'sd8, 32'sd7, 32'sd6, 32'sd5};
`ifdef MAT_STREAM_TRANSPOSE_EN
  localparam logic [63:0] A_B0 = {32'sd3, 32'sd1};
  localparam logic [63:0] A_B1 = {32'sd4, -32'sd2};
  localparam logic [63:0] B_B0 = {32'sd7, 32'sd5};
  localparam logic [63:0] B_B1 = {-32'sd8, 32'sd6};
`else
  localparam logic [63:0] A_B0 = {-32'sd2, 32'sd1};
  localparam logic [63:0] A_B1 = {32'sd4, 32'sd3};
  localparam logic [63:0] B_B0 = {32'sd6, 32'sd5};
  localparam logic [63:0] B_B1 = {-32'sd8, 32'sd7};
`endif

  mat_result_streamer #(
    .W_OUT (W_OUT),
    .N     (N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .valid_in  (valid_in),
    .result_in (result_in),
    .in_ready  (in_ready),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_row     (m_row),
    .m_last    (m_last),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; return at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_beat(input string tag, input logic [63:0] data, input logic row,
                            input logic last);
    check({tag, ".valid"}, 64'(m_valid), 64'd1);
    check({tag, ".data"}, m_data, data);
    check({tag, ".row"}, 64'(m_row), 64'(row));
    check({tag, ".last"}, 64'(m_last), 64'(last));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cen = 1'b1; valid_in = 1'b0; result_in = '0; m_ready = 1'b0;
    @(negedge clk);
    check("rst.valid", 64'(m_valid), 64'd0);
    check("rst.in_ready", 64'(in_ready), 64'd1);
    check("rst.data", m_data, 64'd0);
    check("rst.row", 64'(m_row), 64'd0);
    check("rst.last", 64'(m_last), 64'd0);
    check("rst.overflow", 64'(overflow), 64'd0);
    rst = 1'b0;
    tick();

    // 1: basic drain with m_ready high
    m_ready = 1'b1; valid_in = 1'b1; result_in = MAT_A;
    tick();
    valid_in = 1'b0;
    check_beat("t1.b0", A_B0, 1'b0, 1'b0);
    tick();
    check_beat("t1.b1", A_B1, 1'b1, 1'b1);
    check("t1.in_ready_last", 64'(in_ready), 64'd1);
    tick();
    check("t1.idle_valid", 64'(m_valid), 64'd0);

    // 2: stall for five cycles
    m_ready = 1'b0; valid_in = 1'b1; result_in = MAT_A;
    tick();
    valid_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_beat($sformatf("t2.stall%0d", i), A_B0, 1'b0, 1'b0);
      check($sformatf("t2.in_ready%0d", i), 64'(in_ready), 64'd0);
      tick();
    end
    m_ready = 1'b1;
    check_beat("t2.rel_b0", A_B0, 1'b0, 1'b0);
    tick();
    check_beat("t2.rel_b1", A_B1, 1'b1, 1'b1);
    tick();
    check("t2.idle_valid", 64'(m_valid), 64'd0);

    // 3: chain B onto the last-row accept of A
    valid_in = 1'b1; result_in = MAT_A;
    tick();
    valid_in = 1'b0;
    check_beat("t3.a0", A_B0, 1'b0, 1'b0);
    tick();
    check_beat("t3.a1", A_B1, 1'b1, 1'b1);
    valid_in = 1'b1; result_in = MAT_B;
    check("t3.in_ready_chain", 64'(in_ready), 64'd1);
    tick();
    valid_in = 1'b0;
    check_beat("t3.b0", B_B0, 1'b0, 1'b0);
    check("t3.overflow", 64'(overflow), 64'd0);
    tick();
    check_beat("t3.b1", B_B1, 1'b1, 1'b1);
    tick();
    check("t3.idle_valid", 64'(m_valid), 64'd0);

    // 4: overflow while stalled on row 0
    m_ready = 1'b0; valid_in = 1'b1; result_in = MAT_A;
    tick();
    result_in = MAT_B;
    tick();
    valid_in = 1'b0;
    check("t4.overflow", 64'(overflow), 64'd1);
    check_beat("t4.a0", A_B0, 1'b0, 1'b0);
    m_ready = 1'b1;
    tick();
    check_beat("t4.a1", A_B1, 1'b1, 1'b1);
    tick();
    check("t4.idle_valid", 64'(m_valid), 64'd0);
    check("t4.overflow_sticky", 64'(overflow), 64'd1);

    // 6: asynchronous reset while on row 0
    m_ready = 1'b0; valid_in = 1'b1; result_in = MAT_A;
    tick();
    valid_in = 1'b0;
    check("t6.pre_valid", 64'(m_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("t6.valid", 64'(m_valid), 64'd0);
    check("t6.in_ready", 64'(in_ready), 64'd1);
    check("t6.overflow", 64'(overflow), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("t6.no_beat", 64'(m_valid), 64'd0);

    // 5: clock enable low mid-stream, ignored valid_in
    m_ready = 1'b1; valid_in = 1'b1; result_in = MAT_A;
    tick();
    valid_in = 1'b0;
    check_beat("t5.a0", A_B0, 1'b0, 1'b0);
    cen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid_in = (i == 1);
      result_in = MAT_B;
      tick();
      check_beat($sformatf("t5.frozen%0d", i), A_B0, 1'b0, 1'b0);
      check($sformatf("t5.overflow%0d", i), 64'(overflow), 64'd0);
    end
    valid_in = 1'b0; cen = 1'b1;
    tick();
    check_beat("t5.a1", A_B1, 1'b1, 1'b1);
    tick();
    check("t5.idle_valid", 64'(m_valid), 64'd0);
    check("t5.overflow_end", 64'(overflow), 64'd0);

    do_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mat_result_streamer.md
Name: mat_result_streamer

Overview:
- Downstream stage of the matrix-multiply unit.
- Captures one complete N×N result matrix (N*N*W_OUT bits) when the multiplier asserts its valid strobe.
- Drains the matrix one row per beat over a valid/ready stream toward the writeback/output path.
- Decouples the multiplier's single-cycle result strobe from a back-pressured consumer.

Parameters:
- W_OUT, 32, width of one signed result element
- N, 8, matrix dimension; rows per matrix and elements per beat
- ROW_W, $clog2(N) (minimum 1), width of the row index

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- cen  in  1  clock enable; when 0 all state holds
- valid_in  in  1  one-cycle strobe: result_in holds a complete matrix
- result_in  in  N*N*W_OUT  signed matrix; element (r,c) at bits [(r*N+c)*W_OUT +: W_OUT]
- in_ready  out  1  streamer can accept a matrix this cycle
- m_valid  out  1  m_data holds a valid row
- m_ready  in  1  consumer accepts the beat
- m_data  out  N*W_OUT  one row; element c at [c*W_OUT +: W_OUT]
- m_row  out  ROW_W  index of the row on m_data
- m_last  out  1  beat is row N-1
- overflow  out  1  sticky: a matrix arrived while in_ready was 0

Behaviour:
- Reset values (async, rst=1): buffer cleared to 0, state IDLE, m_valid=0, m_row=0, m_last=0, overflow=0, in_ready=1. m_data reads 0.
- All register updates are qualified by cen. With cen=0, outputs hold and no handshake completes, even if m_ready=1 or valid_in=1; a valid_in pulse during cen=0 is ignored and does not set overflow.
- State machine (two states):
  - IDLE: in_ready=1, m_valid=0. If valid_in & cen: latch result_in into buffer, row counter ←0, go to STREAM.
  - STREAM: m_valid=1, m_data = buffer row[row counter], m_row = row counter, m_last = (row counter == N-1).
    - On m_valid & m_ready & cen and not last: row counter +1.
    - On last-row accept: go to IDLE, or chain (below).
- in_ready = IDLE OR (STREAM & m_last & m_ready). This is combinational from m_ready and permits back-to-back matrices with no bubble.
- Chaining: last-row accept and valid_in in the same enabled cycle:
  - Latch the new matrix.
  - Row counter ←0.
  - Stay in STREAM, so m_valid stays 1 and the next cycle shows row 0 of the new matrix.
- Latency: valid_in cycle T → m_valid=1 with row 0 at T+1. One beat per accepted cycle. A full matrix drains in N cycles with m_ready held high.
- m_data/m_row/m_last are stable while m_valid=1 and m_ready=0. The consumer may stall indefinitely.
- valid_in while in_ready=0: matrix dropped, buffer untouched, overflow←1 (sticky until rst).
- Row counter never exceeds N-1. Wrap occurs only via the last-row transition.
- rst mid-stream: immediate abort, no further beats. The partially drained matrix is lost.

Optional Feature:
- Macro: MAT_STREAM_TRANSPOSE_EN.
- Defined: beat k carries column k, with m_data[r*W_OUT +: W_OUT] = element (r,k). m_row reports k. Timing and handshake are unchanged.
- Undefined: row order as specified above.

Decomposition:
- Package mat_stream_pkg holds:
  - state typedef (IDLE, STREAM)
  - function computing ROW_W from N
  - element-offset helper (r*N+c)*W_OUT, shared with the multiplier-side packing
- Sub-module mat_row_select: purely combinational N:1 row (or column) mux from the flat buffer, indexed by the row counter. It is where the transpose option is applied.
- FSM, buffer and counter live in the top.

Test Plan:
1. N=2, W_OUT=32, m_ready=1. Pulse valid_in with elements (0,0)=1, (0,1)=-2, (1,0)=3, (1,1)=4. Expect:
   - T+1: m_data={-2,1}, m_row=0, m_last=0.
   - T+2: m_data={4,3}, m_row=1, m_last=1.
   - T+3: m_valid=0.
2. Same matrix with m_ready=0 for 5 cycles after T+1 → row 0 held stable for all 5 cycles. Release → rows 0 and 1 on consecutive cycles.
3. Chaining: pulse valid_in with matrix B in the cycle row 1 of matrix A is accepted. Expect:
   - m_valid continuously 1.
   - Next cycle shows B row 0.
   - overflow=0.
4. Overflow: pulse valid_in while streaming row 0 with m_ready=0. Expect overflow=1, and the original matrix still streams unchanged.
5. cen=0 for 3 cycles mid-stream with m_ready=1 → row index frozen, no beats consumed. A valid_in pulse in that window is ignored and overflow stays 0.
6. Assert rst while on row 0 → m_valid=0, in_ready=1, overflow=0 immediately. With MAT_STREAM_TRANSPOSE_EN, test 1 yields {3,1} then {4,-2}.
